// File: rtl/adder_operand_sequencer.sv
// Operand sequencer for a three-operand adder datapath.
//
// Takes a stream of words over a valid/ready handshake and packs each group of
// three into a, b and c. It then holds the operands stable for the adder's
// latency, captures the adder's sum y, and offers it downstream over a second
// valid/ready handshake. Only one triple is in flight at a time.
//
// Parameters:
//   WIDTH    operand/result width
//   LATENCY  adder latency in clock edges (0 = combinational adder)
//
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   in_data, in_valid, in_ready operand word stream
//   a, b, c                     registered operands to the adder
//   y                           sum returned from the adder
//   out_data, out_valid,
//   out_ready                   captured sum stream
//   out_carry                   bits [WIDTH+1:WIDTH] of a+b+c (ADDER_SEQ_CARRY_EN only)
//   busy                        high whenever not collecting operands
//
// Build option: define ADDER_SEQ_CARRY_EN to add the out_carry port and an
// internal wide sum that produces it.
module adder_operand_sequencer #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef ADDER_SEQ_CARRY_EN
  output logic [1:0]       out_carry,
`endif
  output logic             busy
);

  // $clog2(1) is 0, so a zero-latency build still needs a one-bit counter.
  localparam int unsigned CntW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    StCollect,
    StWait,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

`ifdef ADDER_SEQ_CARRY_EN
  logic [1:0]       carry_q, carry_d;
  logic [WIDTH+1:0] sum_full;

  // Operands are held in WAIT, so this wide sum matches the y being captured.
  assign sum_full = {2'b00, a_q} + {2'b00, b_q} + {2'b00, c_q};
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;
`ifdef ADDER_SEQ_CARRY_EN
    carry_d     = carry_q;
`endif

    case (state_q)
      StCollect: begin
        in_ready = 1'b1;
        if (in_valid) begin
          case (idx_q)
            2'd0: begin
              a_d   = in_data;
              idx_d = 2'd1;
            end
            2'd1: begin
              b_d   = in_data;
              idx_d = 2'd2;
            end
            2'd2: begin
              c_d     = in_data;
              idx_d   = 2'd0;
              cnt_d   = CntW'(LATENCY);
              state_d = StWait;
            end
            default: idx_d = 2'd0;
          endcase
        end
      end

      StWait: begin
        // cnt reaching zero marks the edge on which y reflects the held operands.
        if (cnt_q == '0) begin
          out_data_d  = y;
          out_valid_d = 1'b1;
          state_d     = StDone;
`ifdef ADDER_SEQ_CARRY_EN
          carry_d     = 2'(sum_full >> WIDTH);
`endif
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StCollect;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        state_d     = StCollect;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StCollect;
      idx_q       <= 2'd0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef ADDER_SEQ_CARRY_EN
      carry_q     <= 2'b00;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
`ifdef ADDER_SEQ_CARRY_EN
      carry_q     <= carry_d;
`endif
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign c         = c_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != StCollect);
`ifdef ADDER_SEQ_CARRY_EN
  assign out_carry = carry_q;
`endif

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Bench for adder_operand_sequencer: instance 0 uses LATENCY=2 with a
// registered adder model, instance 1 uses LATENCY=0 with a combinational adder.
module tb_adder_operand_sequencer;

  localparam int unsigned W = 16;

  typedef struct {
    logic [W-1:0] d;
    logic [1:0]   cy;
    int           e;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in_data   [2];
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic [W-1:0] a         [2];
  logic [W-1:0] b         [2];
  logic [W-1:0] c         [2];
  logic [W-1:0] out_data  [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic         busy      [2];
`ifdef ADDER_SEQ_CARRY_EN
  logic [1:0]   out_carry [2];
`endif

  int tests_run = 0;
  int fails     = 0;
  int cyc       = 0;
  bit rnd       = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    tests_run++;
    fails++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 2 : 0;

    logic [W-1:0] y_w, s_q, y_q;
    int           pending = 0;
    int           nw = 0;
    logic [W-1:0] w [3];
    exp_t         eq [$];
    exp_t         e;
    logic         ovp = 1'b0;
    logic         acc;
    logic [W+1:0] full;

    // Adder models: two register stages, or purely combinational.
    always @(posedge clk) begin
      s_q <= a[g] + b[g] + c[g];
      y_q <= s_q;
    end
    assign y_w = (L == 2) ? y_q : W'(a[g] + b[g] + c[g]);

    adder_operand_sequencer #(
      .WIDTH  (W),
      .LATENCY(L)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .a        (a[g]),
      .b        (b[g]),
      .c        (c[g]),
      .y        (y_w),
      .out_data (out_data[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
`ifdef ADDER_SEQ_CARRY_EN
      .out_carry(out_carry[g]),
`endif
      .busy     (busy[g])
    );

    // Reference model and scoreboard: words accumulate into triples; each
    // completed triple queues its sum and the edge on which it must appear.
    always @(negedge clk) begin
      if (!rst_n) begin
        pending = 0;
        nw      = 0;
        eq.delete();
        ovp     = 1'b0;
      end else begin
        chk($sformatf("in_ready[%0d]", g), 32'(in_ready[g]), 32'(pending == 0));
        chk($sformatf("busy[%0d]", g), 32'(busy[g]), 32'(pending != 0));
        acc = in_valid[g] && (pending == 0);
        if (out_valid[g] && !ovp) begin
          if (eq.size() == 0) begin
            fail_now($sformatf("unexpected out_valid[%0d] out_data=%0h", g, out_data[g]));
          end else begin
            e = eq.pop_front();
            chk($sformatf("out_data[%0d]", g), 32'(out_data[g]), 32'(e.d));
            chk($sformatf("latency_edge[%0d]", g), 32'(cyc), 32'(e.e));
            chk($sformatf("a[%0d]", g), 32'(a[g]), 32'(e.a));
            chk($sformatf("b[%0d]", g), 32'(b[g]), 32'(e.b));
            chk($sformatf("c[%0d]", g), 32'(c[g]), 32'(e.c));
`ifdef ADDER_SEQ_CARRY_EN
            chk($sformatf("out_carry[%0d]", g), 32'(out_carry[g]), 32'(e.cy));
`endif
          end
        end
        if (out_valid[g] && out_ready[g] && pending > 0) pending = pending - 1;
        if (acc) begin
          w[nw] = in_data[g];
          nw    = nw + 1;
          if (nw == 3) begin
            full = {2'b00, w[0]} + {2'b00, w[1]} + {2'b00, w[2]};
            e.d  = full[W-1:0];
            e.cy = full[W+1:W];
            e.e  = cyc + 1 + int'(L) + 1;
            e.a  = w[0];
            e.b  = w[1];
            e.c  = w[2];
            eq.push_back(e);
            pending = pending + 1;
            nw      = 0;
          end
        end
        ovp = out_valid[g];
      end
    end
  end

  // Present one word and hold it until it transfers; returns at posedge+1.
  task automatic send(input int k, input logic [W-1:0] d);
    int  t;
    bit  ok;
    t  = 0;
    ok = 0;
    in_data[k]  = d;
    in_valid[k] = 1'b1;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = in_ready[k];
      @(posedge clk);
      #1;
      t++;
      if (!ok && rnd) out_ready[k] = 1'($urandom_range(0, 1));
    end
    if (!ok) fail_now($sformatf("send timeout[%0d] word=%0h", k, d));
    in_valid[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int k);
    int t;
    t = 0;
    while (!out_valid[k] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid[k]) fail_now($sformatf("out_valid[%0d] timeout", k));
  endtask

  // Asynchronous reset pulse mid-cycle; values must clear before any edge.
  task automatic reset_pulse();
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst a[%0d]", k), 32'(a[k]), 32'h0);
      chk($sformatf("rst b[%0d]", k), 32'(b[k]), 32'h0);
      chk($sformatf("rst c[%0d]", k), 32'(c[k]), 32'h0);
      chk($sformatf("rst out_data[%0d]", k), 32'(out_data[k]), 32'h0);
      chk($sformatf("rst out_valid[%0d]", k), 32'(out_valid[k]), 32'h0);
      chk($sformatf("rst busy[%0d]", k), 32'(busy[k]), 32'h0);
`ifdef ADDER_SEQ_CARRY_EN
      chk($sformatf("rst out_carry[%0d]", k), 32'(out_carry[k]), 32'h0);
`endif
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_data[k]   = '0;
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
    end

    // Reset and ready after release.
    reset_pulse();
    @(negedge clk);
    chk("in_ready after reset[0]", 32'(in_ready[0]), 32'h1);
    chk("in_ready after reset[1]", 32'(in_ready[1]), 32'h1);
    @(posedge clk);
    #1;

    // Partial triple is discarded by reset: next word must land in a.
    send(0, 16'h1234);
    chk("partial a", 32'(a[0]), 32'h1234);
    reset_pulse();

    // Back-to-back 1,2,3 with a registered adder.
    send(0, 16'd1);
    send(0, 16'd2);
    send(0, 16'd3);
    wait_valid(0);
    chk("sum 1+2+3", 32'(out_data[0]), 32'h6);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("one-cycle pulse", 32'(out_valid[0]), 32'h0);
    @(posedge clk);
    #1;

    // Wraparound.
    send(0, 16'hFFFF);
    send(0, 16'hFFFF);
    send(0, 16'h0002);
    wait_valid(0);
    chk("wrap sum", 32'(out_data[0]), 32'h0);
    @(posedge clk);
    #1;

    // Backpressure: result held, pending word not consumed.
    out_ready[0] = 1'b0;
    send(0, 16'h0011);
    send(0, 16'h0022);
    send(0, 16'h0033);
    wait_valid(0);
    @(posedge clk);
    #1;
    in_data[0]  = 16'h00AA;
    in_valid[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp out_valid", 32'(out_valid[0]), 32'h1);
      chk("bp in_ready", 32'(in_ready[0]), 32'h0);
      chk("bp out_data", 32'(out_data[0]), 32'h66);
      chk("bp a held", 32'(a[0]), 32'h11);
    end
    @(posedge clk);
    #1;
    out_ready[0] = 1'b1;
    send(0, 16'h00AA);
    chk("AA becomes a", 32'(a[0]), 32'hAA);
    send(0, 16'h0001);
    send(0, 16'h0002);
    idle(6);

    // Reset while waiting on the adder.
    send(0, 16'd7);
    send(0, 16'd8);
    send(0, 16'd9);
    reset_pulse();
    send(0, 16'd4);
    send(0, 16'd5);
    send(0, 16'd6);
    wait_valid(0);
    chk("sum 4+5+6", 32'(out_data[0]), 32'hF);
    idle(2);

    // Combinational adder with gaps between words.
    send(1, 16'd10);
    idle(2);
    send(1, 16'd20);
    idle(2);
    send(1, 16'd30);
    wait_valid(1);
    chk("sum 10+20+30", 32'(out_data[1]), 32'h3C);
    idle(2);

    // Randomized traffic with random gaps and backpressure on both instances.
    rnd = 1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 45; i++) begin
        out_ready[k] = 1'($urandom_range(0, 1));
        send(k, W'($urandom()));
        idle(int'($urandom_range(0, 2)));
      end
      out_ready[k] = 1'b1;
      idle(10);
    end
    rnd = 0;

    idle(20);
    chk("drain[0]", 32'(g_dut[0].eq.size()), 32'h0);
    chk("drain[1]", 32'(g_dut[1].eq.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

endmodule
